// File: rtl/ahb_lite_pkg.sv
`default_nettype none
//==============================================================================
// ahb_lite_pkg - shared AHB-Lite encodings and slave state type. Rev 1.0
//==============================================================================
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_byte_lane_decode.sv
`default_nettype none
//==============================================================================
// ahb_byte_lane_decode - address low bits + HSIZE to byte enables. Rev 1.0
//==============================================================================
module ahb_byte_lane_decode #(
  parameter int NB    = 4,
  parameter int OFF_W = 2
) (
  input  logic [OFF_W-1:0] i_addr_lo,
  input  logic [2:0]       i_size,
  output logic [NB-1:0]    o_be,
  output logic             o_misalign
);

  logic [31:0] w_nbytes;
  logic [31:0] w_lo;

  assign w_nbytes   = 32'd1 << i_size;
  assign w_lo       = 32'(i_addr_lo);
  assign o_misalign = (w_lo & (w_nbytes - 32'd1)) != 32'd0;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign o_be[b] = (32'(b) >= w_lo) && (32'(b) < (w_lo + w_nbytes));
  end

endmodule
`default_nettype wire

// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
//==============================================================================
// ahb_lite_mem_slave - AHB-Lite memory slave, wait states, byte lanes, ERROR. Rev 1.0
//==============================================================================
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int         c_NB       = DATA_W / 8;
  localparam int         c_OFF_W    = $clog2(c_NB);
  localparam int         c_IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0] c_MAX_SIZE = 3'(c_OFF_W);

  slave_state_e       r_state, w_next;
  logic [3:0]         r_cnt;
  logic [c_IDX_W-1:0] r_idx, w_idx, w_rd_idx;
  logic [c_NB-1:0]    r_be, w_be;
  logic               r_write, r_err;
  logic               w_misalign, w_err, w_accept, w_rd_write, w_load, w_fwd;
  logic [DATA_W-1:0]  w_rd_word;
  logic [DATA_W-1:0]  r_mem [MEM_DEPTH];

  ahb_byte_lane_decode #(.NB(c_NB), .OFF_W(c_OFF_W)) u_lane_decode (
    .i_addr_lo  (HADDR[c_OFF_W-1:0]),
    .i_size     (HSIZE),
    .o_be       (w_be),
    .o_misalign (w_misalign)
  );

  assign w_idx = HADDR[c_OFF_W +: c_IDX_W];
  assign w_err = ((HADDR >> c_OFF_W) >= ADDR_W'(MEM_DEPTH)) || (HSIZE > c_MAX_SIZE) || w_misalign;

  // New address phases are only sampled in states that drive HREADYOUT high.
  assign w_accept = HSEL && HREADY && (htrans_e'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ})
                    && (r_state inside {ST_IDLE, ST_DATA, ST_ERR2});

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!w_accept)            w_next = ST_IDLE;
        else if (w_err)           w_next = ST_ERR1;
        else if (WAIT_STATES > 0) w_next = ST_WAIT;
        else                      w_next = ST_DATA;
      end
      ST_WAIT: if (r_cnt == 4'(WAIT_STATES - 1)) w_next = ST_DATA;
      ST_ERR1: w_next = ST_ERR2;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (r_state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_be    <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= (r_state == ST_WAIT && w_next == ST_WAIT) ? r_cnt + 4'd1 : 4'd0;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_be    <= w_be;
        r_write <= HWRITE;
        r_err   <= w_err;
      end
    end
  end

  // Entering DATA straight from an accept reads the live address; from WAIT, the captured one.
  assign w_rd_idx   = (r_state == ST_WAIT) ? r_idx : w_idx;
  assign w_rd_write = (r_state == ST_WAIT) ? r_write : HWRITE;
  assign w_load     = (w_next == ST_DATA) && !w_rd_write;
  assign w_fwd      = (r_state == ST_DATA) && r_write && (r_idx == w_rd_idx);

  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    for (int b = 0; b < c_NB; b++) begin
      if (w_fwd && r_be[b]) w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET)      HRDATA <= '0;
    else if (w_load) HRDATA <= w_rd_word;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && r_state == ST_DATA && r_write && !r_err) begin
      for (int b = 0; b < c_NB; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire
